divu_iter: RTL and testbench



---
 rtl/divu_pkg.sv | 15 +
 rtl/divu_step.sv | 21 ++
 rtl/divu_iter.sv | 120 ++++++++++++
 tb/tb_divu_iter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/divu_pkg.sv
// Shared state encoding and sizing helpers for the iterative unsigned divider.
package divu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } divu_state_e;

    // One extra bit so the cycle counter can also hold N/R without wrapping.
    function automatic int cnt_width(input int n, input int r);
        return $clog2(n / r) + 1;
    endfunction

endpackage

// File: rtl/divu_step.sv
// One combinational restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module divu_step #(
    parameter int N = 256
) (
    input  logic [N:0]   prem,
    input  logic [N-1:0] divisor,
    input  logic         bit_in,
    output logic [N:0]   prem_next,
    output logic         q_bit
);
    logic [N:0] shifted;

    assign shifted = {prem[N-1:0], bit_in};

    // If prem[N] is set, the true shifted value exceeds 2^(N+1) > divisor, so the
    // subtraction must happen. The modular difference is still exact because
    // the true result is below the divisor.
    assign q_bit     = prem[N] | (shifted >= {1'b0, divisor});
    assign prem_next = q_bit ? (shifted - {1'b0, divisor}) : shifted;

endmodule

// File: rtl/divu_iter.sv
// Iterative unsigned divider, R quotient bits per cycle, valid/ready on both sides.
// Define DIVU_ITER_EARLY_OUT_EN to finish in one cycle whenever dividend < divisor.
module divu_iter
    import divu_pkg::*;
#(
    parameter int N = 256,
    parameter int R = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         dbz,
    output logic         busy
);
    localparam int            CW      = cnt_width(N, R);
    localparam logic [CW-1:0] LAST    = CW'(N / R - 1);
    localparam logic [1:0]    ST_IDLE = IDLE;
    localparam logic [1:0]    ST_RUN  = RUN;
    localparam logic [1:0]    ST_DONE = DONE;

    if ((N < 2) || (R < 1) || (N % R != 0)) begin : g_param_check
        $error("divu_iter: N must be >= 2 and R must divide N");
    end

    logic [1:0]    state;
    logic [N-1:0]  dvd_sh;
    logic [N-1:0]  dsr;
    logic [N:0]    prem;
    logic [N-1:0]  qacc;
    logic [CW-1:0] cnt;

    logic [N:0]    rem_chain [R+1];
    logic [R-1:0]  qbits;
    logic [N-1:0]  q_next;
    logic          accept;

    assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);

    // R steps chained MSB first; dividend bits come off the top of the shift register.
    assign rem_chain[0] = prem;
    for (genvar i = 0; i < R; i++) begin : g_step
        divu_step #(.N(N)) u_step (
            .prem      (rem_chain[i]),
            .divisor   (dsr),
            .bit_in    (dvd_sh[N-1-i]),
            .prem_next (rem_chain[i+1]),
            .q_bit     (qbits[R-1-i])
        );
    end

    assign q_next = (qacc << R) | N'(qbits);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            dvd_sh    <= '0;
            dsr       <= '0;
            prem      <= '0;
            qacc      <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
        end else if (accept) begin
            dvd_sh <= dividend;
            dsr    <= divisor;
            prem   <= '0;
            qacc   <= '0;
            cnt    <= '0;
            if (divisor == '0) begin
                quotient  <= '1;
                remainder <= dividend;
                dbz       <= 1'b1;
                state     <= ST_DONE;
`ifdef DIVU_ITER_EARLY_OUT_EN
            end else if (dividend < divisor) begin
                quotient  <= '0;
                remainder <= dividend;
                dbz       <= 1'b0;
                state     <= ST_DONE;
`endif
            end else begin
                state <= ST_RUN;
            end
        end else begin
            case (state)
                ST_RUN: begin
                    prem   <= rem_chain[R];
                    qacc   <= q_next;
                    dvd_sh <= dvd_sh << R;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        quotient  <= q_next;
                        remainder <= rem_chain[R][N-1:0];
                        dbz       <= 1'b0;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: ;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divu_iter.sv
// Bench for divu_iter: R=1 and R=4 instances share stimulus; per-instance scoreboards check results and latency.
module tb_divu_iter;
    localparam int N = 256;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [N-1:0] dividend = '0;
    logic [N-1:0] divisor = '0;

    logic         rdy [2];
    logic         ov  [2];
    logic         dz  [2];
    logic         bsy [2];
    logic [N-1:0] qo  [2];
    logic [N-1:0] ro  [2];

    always #5 clk = ~clk;

    divu_iter #(.N(N), .R(1)) u_r1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]),
        .dividend(dividend), .divisor(divisor), .out_valid(ov[0]), .out_ready(out_ready),
        .quotient(qo[0]), .remainder(ro[0]), .dbz(dz[0]), .busy(bsy[0])
    );

    divu_iter #(.N(N), .R(4)) u_r4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]),
        .dividend(dividend), .divisor(divisor), .out_valid(ov[1]), .out_ready(out_ready),
        .quotient(qo[1]), .remainder(ro[1]), .dbz(dz[1]), .busy(bsy[1])
    );

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         d;
        int           lat;
        int           acc;
    } exp_t;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         d;
    } vec_t;

    exp_t sb0[$];
    exp_t sb1[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   vs [2] = '{0, 0};
    int   vc [2] = '{0, 0};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int exp_lat(input logic [N-1:0] a, input logic [N-1:0] b, input int r);
        if (b == '0) return 1;
`ifdef DIVU_ITER_EARLY_OUT_EN
        if (a < b) return 1;
`endif
        return N / r + 1;
    endfunction

    // Output monitor: latency measured from the accepting edge (counted as edge 1).
    always begin
        @(negedge clk);
        #2;
        if (!rst) begin
            vs[0] = 0;
            vs[1] = 0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                int   rr;
                int   n;
                exp_t e;
                rr = (k == 0) ? 1 : 4;
                if (ov[k] && !vs[k]) begin
                    vs[k] = 1;
                    vc[k] = cyc;
                end
                if (ov[k] && out_ready) begin
                    n = (k == 0) ? sb0.size() : sb1.size();
                    if (n == 0) begin
                        chk($sformatf("unexpected_result_r%0d", rr), 1, 0);
                    end else begin
                        if (k == 0) e = sb0.pop_front();
                        else        e = sb1.pop_front();
                        chk($sformatf("quotient_r%0d", rr), qo[k], e.q);
                        chk($sformatf("remainder_r%0d", rr), ro[k], e.r);
                        chk($sformatf("dbz_r%0d", rr), dz[k], e.d);
                        chk($sformatf("latency_r%0d", rr), vc[k] - e.acc + 1, e.lat);
                    end
                    vs[k] = 0;
                end
            end
        end
    end

    task automatic push_exp(input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic [N-1:0] q, input logic [N-1:0] r, input logic d);
        exp_t e;
        e.q = q; e.r = r; e.d = d; e.acc = cyc + 1;
        e.lat = exp_lat(a, b, 1);
        sb0.push_back(e);
        e.lat = exp_lat(a, b, 4);
        sb1.push_back(e);
    endtask

    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] q, input logic [N-1:0] r, input logic d);
        @(negedge clk);
        #1;
        for (int i = 0; i < 600 && !(rdy[0] && rdy[1]); i++) begin
            @(negedge clk);
            #1;
        end
        if (!(rdy[0] && rdy[1])) begin
            chk("accept_timeout", 0, 1);
            return;
        end
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        push_exp(a, b, q, r, d);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 600 && (sb0.size() + sb1.size()) != 0; i++) @(negedge clk);
        chk("drain_pending", sb0.size() + sb1.size(), 0);
    endtask

    task automatic chk_reset(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_in_ready_%0d", tag, k), rdy[k], 1);
            chk($sformatf("%s_out_valid_%0d", tag, k), ov[k], 0);
            chk($sformatf("%s_busy_%0d", tag, k), bsy[k], 0);
            chk($sformatf("%s_dbz_%0d", tag, k), dz[k], 0);
            chk($sformatf("%s_quotient_%0d", tag, k), qo[k], 0);
            chk($sformatf("%s_remainder_%0d", tag, k), ro[k], 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t         vt [14];
        logic [N-1:0] ones;
        logic [N-1:0] fives;
        ones  = '1;
        fives = {64{4'h5}};
        vt[0]  = '{a: 100, b: 7, q: 14, r: 2, d: 0};
        vt[1]  = '{a: ones, b: 3, q: fives, r: 0, d: 0};
        vt[2]  = '{a: ones, b: ones, q: 1, r: 0, d: 0};
        vt[3]  = '{a: 'h1234, b: 0, q: ones, r: 'h1234, d: 1};
        vt[4]  = '{a: 9, b: 3, q: 3, r: 0, d: 0};
        vt[5]  = '{a: 5, b: 9, q: 0, r: 5, d: 0};
        vt[6]  = '{a: 0, b: 5, q: 0, r: 0, d: 0};
        vt[7]  = '{a: ones, b: 1, q: ones, r: 0, d: 0};
        vt[8]  = '{a: ones, b: 0, q: ones, r: ones, d: 1};
        vt[9]  = '{a: ones - 1, b: ones, q: 0, r: ones - 1, d: 0};
        vt[10] = '{a: 256'h1 << 255, b: 256'h1 << 128, q: 256'h1 << 127, r: 0, d: 0};
        for (int i = 11; i < 14; i++) begin
            vt[i].a = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            vt[i].b = (i == 11) ? N'($urandom | 1) : {$urandom, $urandom, $urandom, ($urandom | 32'h1)};
            vt[i].q = vt[i].a / vt[i].b;
            vt[i].r = vt[i].a % vt[i].b;
            vt[i].d = 1'b0;
        end

        repeat (3) @(negedge clk);
        #1;
        chk_reset("reset");
        rst = 1'b1;

        for (int i = 0; i < 14; i++) begin
            send(vt[i].a, vt[i].b, vt[i].q, vt[i].r, vt[i].d);
            wait_drain();
        end

        // Backpressure: results must hold while inputs churn, then back-to-back accept.
        out_ready = 1'b0;
        send(1000, 7, 142, 6, 0);
        for (int i = 0; i < 600 && !(ov[0] && ov[1]); i++) begin
            @(negedge clk);
            #1;
        end
        chk("bp_both_valid", ov[0] && ov[1], 1);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            dividend = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            divisor  = N'($urandom);
            in_valid = ~in_valid;
            #1;
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("bp_in_ready_%0d", k), rdy[k], 0);
                chk($sformatf("bp_out_valid_%0d", k), ov[k], 1);
                chk($sformatf("bp_quotient_%0d", k), qo[k], 142);
                chk($sformatf("bp_remainder_%0d", k), ro[k], 6);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        dividend  = 77;
        divisor   = 7;
        in_valid  = 1'b1;
        #1;
        chk("b2b_in_ready_0", rdy[0], 1);
        chk("b2b_in_ready_1", rdy[1], 1);
        push_exp(77, 7, 11, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        wait_drain();

        // Reset during RUN discards the R=1 operation.
        send(100, 7, 14, 2, 0);
        repeat (99) @(negedge clk);
        #1;
        chk("run_busy_r1", bsy[0], 1);
        chk("run_in_ready_r1", rdy[0], 0);
        chk("run_out_valid_r1", ov[0], 0);
        rst = 1'b0;
        #1;
        chk_reset("midrun_rst");
        sb0.delete();
        sb1.delete();
        repeat (2) @(negedge clk);
        #1;
        chk_reset("held_rst");
        rst = 1'b1;
        send(50, 5, 10, 0, 0);
        wait_drain();

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
